// File: rtl/cart_header.sv
// cart_header: snoops the ROM download stream and decodes the cartridge header
// into static mapper configuration. Outputs are cleared when a download starts
// and are registered one cycle after the download ends.
// Optional feature macro: CART_HDR_CHECKSUM_EN builds the header checksum
// compare. Without it, header_ok simply follows hdr_valid.

module cart_header (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic [7:0]  cart_mbc_type,
  output logic        mbc1,
  output logic        mbc1m,
  output logic        mbc2,
  output logic        mbc3,
  output logic        mbc30,
  output logic        mbc5,
  output logic        mbc6,
  output logic        mbc7,
  output logic        mmm01,
  output logic        huc1,
  output logic        huc3,
  output logic        gb_camera,
  output logic        tama,
  output logic [8:0]  rom_mask,
  output logic [3:0]  ram_mask,
  output logic        has_ram,
  output logic        isGBC_game,
  output logic        header_ok,
  output logic        hdr_valid
);

  typedef enum logic [1:0] {StIdle, StCapture, StDecode, StDone} state_e;

  typedef struct packed {
    logic [7:0] mbc_type;
    logic       mbc1, mbc1m, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7;
    logic       mmm01, huc1, huc3, gb_camera, tama;
    logic [8:0] rom_mask;
    logic [3:0] ram_mask;
    logic       has_ram;
    logic       is_gbc;
    logic       valid;
  } hdr_out_t;

  state_e      state_q, state_d;
  logic        dl_active_q, dl_active_d;
  logic        cgb_q, cgb_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  romsz_q, romsz_d;
  logic [7:0]  ramsz_q, ramsz_d;
  logic [15:0] sum_a_q, sum_a_d;
  logic [15:0] sum_b_q, sum_b_d;
  hdr_out_t    out_q, out_d, dec;
  logic        start_cap, cap_en;
  logic [24:0] baddr;
  logic [7:0]  bval;
`ifdef CART_HDR_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  hchk_q, hchk_d;
  logic        header_ok_q, header_ok_d;
`endif

  // State register; dl_active history is kept through reset so an interrupted
  // download is not mistaken for a new rising edge.
  always_ff @(posedge clk_sys) begin
    dl_active_q <= dl_active_d;
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    dl_active_d = dl_active;
    state_d     = state_q;
    case (state_q)
      StIdle, StDone: if (dl_active && !dl_active_q) state_d = StCapture;
      StCapture:      if (!dl_active) state_d = StDecode;
      StDecode:       state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Capture byte snooping, clear on download start, output register load in decode
  always_comb begin
    cgb_d     = cgb_q;
    type_d    = type_q;
    romsz_d   = romsz_q;
    ramsz_d   = ramsz_q;
    sum_a_d   = sum_a_q;
    sum_b_d   = sum_b_q;
    out_d     = out_q;
    baddr     = '0;
    bval      = '0;
`ifdef CART_HDR_CHECKSUM_EN
    chk_d       = chk_q;
    hchk_d      = hchk_q;
    header_ok_d = header_ok_q;
`endif
    start_cap = ((state_q == StIdle) || (state_q == StDone)) && dl_active && !dl_active_q;
    cap_en    = start_cap || ((state_q == StCapture) && dl_active);

    if (start_cap) begin
      cgb_d   = 1'b0;
      type_d  = '0;
      romsz_d = '0;
      ramsz_d = '0;
      sum_a_d = '0;
      sum_b_d = '0;
      out_d   = '0;
`ifdef CART_HDR_CHECKSUM_EN
      chk_d       = '0;
      hchk_d      = '0;
      header_ok_d = 1'b0;
`endif
    end

    if (cap_en && dl_wr) begin
      for (int i = 0; i < 2; i++) begin
        // dl_addr is always even, so OR-ing in the lane index gives the byte address
        baddr = dl_addr | 25'(i);
        bval  = dl_data[8*i +: 8];
        if (baddr == 25'h143) cgb_d   = bval[7];
        if (baddr == 25'h147) type_d  = bval;
        if (baddr == 25'h148) romsz_d = bval;
        if (baddr == 25'h149) ramsz_d = bval;
        if (baddr >= 25'h104 && baddr <= 25'h133) sum_a_d = sum_a_d + {8'd0, bval};
        if (baddr >= 25'h40104 && baddr <= 25'h40133) sum_b_d = sum_b_d + {8'd0, bval};
`ifdef CART_HDR_CHECKSUM_EN
        if (baddr == 25'h14D) hchk_d = bval;
        if (baddr >= 25'h134 && baddr <= 25'h14C) chk_d = chk_d - bval - 8'd1;
`endif
      end
    end

    if (state_q == StDecode) begin
      out_d = dec;
`ifdef CART_HDR_CHECKSUM_EN
      header_ok_d = (chk_q == hchk_q);
`endif
    end
  end

  // Header decode from the captured bytes
  always_comb begin
    dec          = '0;
    dec.mbc_type = type_q;
    case (type_q) inside
      [8'h01:8'h03]: dec.mbc1      = 1'b1;
      [8'h05:8'h06]: dec.mbc2      = 1'b1;
      [8'h0B:8'h0D]: dec.mmm01     = 1'b1;
      [8'h0F:8'h13]: dec.mbc3      = 1'b1;
      [8'h19:8'h1E]: dec.mbc5      = 1'b1;
      8'h20:         dec.mbc6      = 1'b1;
      8'h22:         dec.mbc7      = 1'b1;
      8'hFC:         dec.gb_camera = 1'b1;
      8'hFD:         dec.tama      = 1'b1;
      8'hFE:         dec.huc3      = 1'b1;
      8'hFF:         dec.huc1      = 1'b1;
      default:       ;
    endcase
    dec.mbc30 = dec.mbc3 & ((romsz_q == 8'd7) | (ramsz_q == 8'd5));
    // Multicart: a second identical logo copy at the 256 KB boundary
    dec.mbc1m = dec.mbc1 & (romsz_q == 8'd5) & (sum_b_q != 16'd0) & (sum_a_q == sum_b_q);
    if (romsz_q <= 8'd8) dec.rom_mask = 9'((10'd2 << romsz_q[3:0]) - 10'd1);
    else                 dec.rom_mask = 9'h1FF;
    case (ramsz_q)
      8'd3:    dec.ram_mask = 4'd3;
      8'd4:    dec.ram_mask = 4'd15;
      8'd5:    dec.ram_mask = 4'd7;
      default: dec.ram_mask = 4'd0;
    endcase
    dec.has_ram = (ramsz_q != 8'd0) | dec.mbc2 | dec.mbc7 | dec.tama;
    dec.is_gbc  = cgb_q;
    dec.valid   = 1'b1;
  end

  // Capture and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cgb_q   <= 1'b0;
      type_q  <= '0;
      romsz_q <= '0;
      ramsz_q <= '0;
      sum_a_q <= '0;
      sum_b_q <= '0;
      out_q   <= '0;
`ifdef CART_HDR_CHECKSUM_EN
      chk_q       <= '0;
      hchk_q      <= '0;
      header_ok_q <= 1'b0;
`endif
    end else begin
      cgb_q   <= cgb_d;
      type_q  <= type_d;
      romsz_q <= romsz_d;
      ramsz_q <= ramsz_d;
      sum_a_q <= sum_a_d;
      sum_b_q <= sum_b_d;
      out_q   <= out_d;
`ifdef CART_HDR_CHECKSUM_EN
      chk_q       <= chk_d;
      hchk_q      <= hchk_d;
      header_ok_q <= header_ok_d;
`endif
    end
  end

  assign cart_mbc_type = out_q.mbc_type;
  assign mbc1          = out_q.mbc1;
  assign mbc1m         = out_q.mbc1m;
  assign mbc2          = out_q.mbc2;
  assign mbc3          = out_q.mbc3;
  assign mbc30         = out_q.mbc30;
  assign mbc5          = out_q.mbc5;
  assign mbc6          = out_q.mbc6;
  assign mbc7          = out_q.mbc7;
  assign mmm01         = out_q.mmm01;
  assign huc1          = out_q.huc1;
  assign huc3          = out_q.huc3;
  assign gb_camera     = out_q.gb_camera;
  assign tama          = out_q.tama;
  assign rom_mask      = out_q.rom_mask;
  assign ram_mask      = out_q.ram_mask;
  assign has_ram       = out_q.has_ram;
  assign isGBC_game    = out_q.is_gbc;
  assign hdr_valid     = out_q.valid;
`ifdef CART_HDR_CHECKSUM_EN
  assign header_ok     = header_ok_q;
`else
  assign header_ok     = out_q.valid;
`endif

endmodule

// File: tb/tb_cart_header.sv
// Bench for cart_header: randomized headers driven through download transactions,
// checked against a spec-level reference model.

module tb_cart_header;

  logic        clk_sys = 1'b0;
  logic        reset, dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;
  logic [7:0]  cart_mbc_type;
  logic        mbc1, mbc1m, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7;
  logic        mmm01, huc1, huc3, gb_camera, tama;
  logic [8:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic        has_ram, isGBC_game, header_ok, hdr_valid;

  int total = 0;
  int bad   = 0;

  logic [24:0] q_addr[$];
  logic [15:0] q_data[$];

  cart_header dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .cart_mbc_type(cart_mbc_type),
    .mbc1(mbc1), .mbc1m(mbc1m), .mbc2(mbc2), .mbc3(mbc3), .mbc30(mbc30),
    .mbc5(mbc5), .mbc6(mbc6), .mbc7(mbc7), .mmm01(mmm01), .huc1(huc1),
    .huc3(huc3), .gb_camera(gb_camera), .tama(tama), .rom_mask(rom_mask),
    .ram_mask(ram_mask), .has_ram(has_ram), .isGBC_game(isGBC_game),
    .header_ok(header_ok), .hdr_valid(hdr_valid)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [37:0] dut_vec();
    return {cart_mbc_type, mbc1, mbc1m, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01,
            huc1, huc3, gb_camera, tama, rom_mask, ram_mask, has_ram, isGBC_game,
            header_ok, hdr_valid};
  endfunction

  // Reference: the last write wins for header fields; every written byte in a
  // summed range counts, so chk = -(sum of bytes) - (number of bytes) mod 256.
  function automatic logic [37:0] model_vec();
    int unsigned typ = 0, romsz = 0, ramsz = 0, cgb = 0, hchk = 0;
    int unsigned s_chk = 0, n_chk = 0, sa = 0, sb = 0, chk, a, v, romm, ramm;
    logic m1, m1m, m2, m3, m30, m5, m6, m7, mm, h1, h3, cam, tm, hr, ok;
    for (int j = 0; j < q_addr.size(); j++) begin
      for (int b = 0; b < 2; b++) begin
        a = 32'(q_addr[j]) + 32'(b);
        v = (32'(q_data[j]) >> (8 * b)) & 32'hFF;
        if (a == 32'h143) cgb = v;
        if (a == 32'h147) typ = v;
        if (a == 32'h148) romsz = v;
        if (a == 32'h149) ramsz = v;
        if (a == 32'h14D) hchk = v;
        if (a >= 32'h134 && a <= 32'h14C) begin s_chk += v; n_chk++; end
        if (a >= 32'h104 && a <= 32'h133) sa += v;
        if (a >= 32'h40104 && a <= 32'h40133) sb += v;
      end
    end
    chk = (32'd0 - s_chk - n_chk) & 32'hFF;
    m1  = typ >= 1 && typ <= 3;
    m2  = typ == 5 || typ == 6;
    mm  = typ >= 11 && typ <= 13;
    m3  = typ >= 15 && typ <= 19;
    m5  = typ >= 25 && typ <= 30;
    m6  = typ == 32;
    m7  = typ == 34;
    cam = typ == 252;
    tm  = typ == 253;
    h3  = typ == 254;
    h1  = typ == 255;
    m30 = m3 && (romsz == 7 || ramsz == 5);
    m1m = m1 && romsz == 5 && (sb % 65536) != 0 && (sa % 65536) == (sb % 65536);
    romm = (romsz <= 8) ? (32'd2 << romsz) - 1 : 511;
    ramm = (ramsz == 3) ? 3 : (ramsz == 4) ? 15 : (ramsz == 5) ? 7 : 0;
    hr   = ramsz != 0 || m2 || m7 || tm;
`ifdef CART_HDR_CHECKSUM_EN
    ok = (chk == hchk);
`else
    ok = 1'b1;
`endif
    return {8'(typ), m1, m1m, m2, m3, m30, m5, m6, m7, mm, h1, h3, cam, tm,
            9'(romm), 4'(ramm), hr, 1'((cgb >> 7) & 1), ok, 1'b1};
  endfunction

  task automatic push(input logic [24:0] a, input logic [15:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  // logo_mode: 0 no logo, 1 identical copy at 0x40104, 2 copy that differs by one byte
  task automatic build_header(input logic [7:0] typ, input logic [7:0] romsz,
                              input logic [7:0] ramsz, input logic [7:0] cgb,
                              input bit bad_chk, input int logo_mode);
    logic [7:0]  img[0:25];
    logic [7:0]  logo[0:47];
    logic [7:0]  c;
    logic [15:0] d;
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < 48; i++) logo[i] = 8'($urandom);
    for (int i = 0; i < 26; i++) img[i] = 8'($urandom);
    if (logo_mode != 0) begin
      for (int i = 0; i < 48; i += 2) push(25'h104 + 25'(i), {logo[i+1], logo[i]});
      for (int i = 0; i < 48; i += 2) begin
        d = {logo[i+1], logo[i]};
        if (logo_mode == 2 && i == 0) d[7:0] = logo[0] + 8'd1;
        push(25'h40104 + 25'(i), d);
      end
    end
    img[15] = cgb;
    img[19] = typ;
    img[20] = romsz;
    img[21] = ramsz;
    c = 8'd0;
    for (int i = 0; i < 25; i++) c = c - img[i] - 8'd1;
    img[25] = bad_chk ? c + 8'd1 : c;
    for (int i = 0; i < 26; i += 2) push(25'h134 + 25'(i), {img[i+1], img[i]});
  endtask

  task automatic do_download();
    logic [37:0] exp;
    exp = model_vec();
    @(negedge clk_sys);
    dl_active = 1'b1;
    dl_wr     = 1'b0;
    @(negedge clk_sys);
    total++;
    if (dut_vec() !== 38'd0) begin
      bad++;
      $display("FAIL clear_on_start got=%h want=%h", dut_vec(), 38'd0);
    end
    for (int j = 0; j < q_addr.size(); j++) begin
      dl_wr   = 1'b1;
      dl_addr = q_addr[j];
      dl_data = q_data[j];
      @(negedge clk_sys);
      dl_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
    end
    // A write in the falling cycle must be ignored
    dl_active = 1'b0;
    dl_wr     = 1'b1;
    dl_addr   = 25'h146;
    dl_data   = 16'hEEEE;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    total++;
    if (hdr_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_early got=%b want=0", hdr_valid);
    end
    @(negedge clk_sys);
    total++;
    if (dut_vec() !== exp) begin
      bad++;
      $display("FAIL decode got=%h want=%h", dut_vec(), exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    total++;
    if (dut_vec() !== 38'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(), 38'd0);
    end
    reset = 1'b0;
    @(negedge clk_sys);
    total++;
    if (dut_vec() !== 38'd0) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", dut_vec(), 38'd0);
    end
  endtask

  task automatic test_mbc1();
    build_header(8'h03, 8'h05, 8'h03, 8'($urandom), 1'b0, 2);
    do_download();
    total++;
    if ({mbc1, mbc1m, rom_mask, ram_mask, has_ram, hdr_valid} !== {1'b1, 1'b0, 9'h03F, 4'd3, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL mbc1_fields got=%b%b_%h_%h_%b%b want=10_03f_3_11",
               mbc1, mbc1m, rom_mask, ram_mask, has_ram, hdr_valid);
    end
  endtask

  task automatic test_mbc1m();
    build_header(8'h03, 8'h05, 8'h03, 8'($urandom), 1'b0, 1);
    do_download();
    total++;
    if ({mbc1, mbc1m} !== 2'b11) begin
      bad++;
      $display("FAIL mbc1m got=%b%b want=11", mbc1, mbc1m);
    end
  endtask

  task automatic test_mbc3_mbc2();
    build_header(8'h13, 8'h02, 8'h05, 8'($urandom), 1'b0, 0);
    do_download();
    total++;
    if ({mbc3, mbc30, ram_mask} !== {1'b1, 1'b1, 4'd7}) begin
      bad++;
      $display("FAIL mbc30 got=%b%b_%h want=11_7", mbc3, mbc30, ram_mask);
    end
    build_header(8'h06, 8'h01, 8'h00, 8'($urandom), 1'b0, 0);
    do_download();
    total++;
    if ({mbc2, has_ram, ram_mask} !== {1'b1, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL mbc2 got=%b%b_%h want=11_0", mbc2, has_ram, ram_mask);
    end
  endtask

  task automatic test_checksum();
    logic want;
    build_header(8'h01, 8'h00, 8'h00, 8'h80, 1'b0, 0);
    do_download();
    total++;
    if (header_ok !== 1'b1) begin
      bad++;
      $display("FAIL chk_good got=%b want=1", header_ok);
    end
    build_header(8'h01, 8'h00, 8'h00, 8'h80, 1'b1, 0);
    do_download();
`ifdef CART_HDR_CHECKSUM_EN
    want = 1'b0;
`else
    want = 1'b1;
`endif
    total++;
    if (header_ok !== want) begin
      bad++;
      $display("FAIL chk_bad got=%b want=%b", header_ok, want);
    end
  endtask

  task automatic test_reset_mid_capture();
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    dl_wr   = 1'b1;
    dl_addr = 25'h146;
    dl_data = 16'h1900;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    dl_active = 1'b0;
    repeat (4) @(negedge clk_sys);
    total++;
    if (dut_vec() !== 38'd0) begin
      bad++;
      $display("FAIL reset_mid_capture got=%h want=%h", dut_vec(), 38'd0);
    end
  endtask

  task automatic test_back_to_back();
    build_header(8'h22, 8'h03, 8'h00, 8'($urandom), 1'b0, 0);
    do_download();
    total++;
    if (mbc7 !== 1'b1) begin
      bad++;
      $display("FAIL mbc7 got=%b want=1", mbc7);
    end
    build_header(8'hFF, 8'h04, 8'h02, 8'($urandom), 1'b0, 0);
    do_download();
    total++;
    if ({huc1, mbc7} !== 2'b10) begin
      bad++;
      $display("FAIL huc1_after_mbc7 got=%b%b want=10", huc1, mbc7);
    end
  endtask

  task automatic test_single_cycle();
    q_addr.delete();
    q_data.delete();
    do_download();
    total++;
    if ({cart_mbc_type, rom_mask, ram_mask, has_ram, header_ok, hdr_valid} !==
        {8'h00, 9'h001, 4'd0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL empty_header got=%h_%h_%h_%b%b%b want=00_001_0_011",
               cart_mbc_type, rom_mask, ram_mask, has_ram, header_ok, hdr_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] typ, romsz, ramsz;
    for (int n = 0; n < 12; n++) begin
      typ   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom_range(0, 40));
      romsz = 8'($urandom_range(0, 10));
      ramsz = 8'($urandom_range(0, 6));
      build_header(typ, romsz, ramsz, 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1)
          push(25'($urandom_range(32'h100, 32'h150)) & 25'h1FFFFFE, 16'($urandom));
        else
          push(25'($urandom_range(0, 32'h40140)) & 25'h1FFFFFE, 16'($urandom));
      end
      // Repeated write: type is overwritten, checksum counts the word twice
      if ($urandom_range(0, 1) == 1) push(25'h146, {8'($urandom), 8'($urandom)});
      do_download();
    end
  endtask

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    test_reset();
    test_single_cycle();
    test_mbc1();
    test_mbc1m();
    test_mbc3_mbc2();
    test_checksum();
    test_reset_mid_capture();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_header.md
# cart_header

Snoops the ROM download stream and turns the cartridge header into the static configuration the mapper block consumes. It sits directly upstream of the mapper block and latches one mapper select per family, plus `cart_mbc_type`, `rom_mask`, `ram_mask`, `has_ram`, `isGBC_game` and the MBC1 multicart flag. Outputs are frozen once a download completes and remain stable until the next download starts. `rocket` and `sachen` are not header-detectable and are driven elsewhere.

## Interface
- No parameters.
- `clk_sys`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `dl_active`  in  1  ROM download in progress
- `dl_wr`  in  1  one-cycle write strobe; ignored while `dl_active`=0
- `dl_addr`  in  25  byte address of the word; always even
- `dl_data`  in  16  `[7:0]` is the byte at `dl_addr`, `[15:8]` is the byte at `dl_addr+1`
- `cart_mbc_type`  out  8  header byte 0x147
- `mbc1 mbc1m mbc2 mbc3 mbc30 mbc5 mbc6 mbc7 mmm01 huc1 huc3 gb_camera tama`  out  1 each  mapper selects
- `rom_mask`  out  9  16 KB bank mask
- `ram_mask`  out  4  8 KB bank mask
- `has_ram`  out  1  cart RAM or EEPROM present
- `isGBC_game`  out  1  header byte 0x143 bit 7
- `header_ok`  out  1  header checksum matched
- `hdr_valid`  out  1  all outputs above are decoded and stable

## Operation
- **States:** IDLE, CAPTURE, DECODE, DONE.
- **IDLE/DONE → CAPTURE** on the first cycle `dl_active`=1.
  - Clears all capture registers and drops `hdr_valid`.
  - Every decoded output goes to 0.
- **CAPTURE:** on each `dl_wr`, both bytes of the word are examined by address.
  - 0x143 → cgb; 0x147 → type; 0x148 → romsz; 0x149 → ramsz; 0x14D → hchk.
  - 0x134–0x14C: `chk = chk - byte - 1` (8-bit, wraps, init 0).
  - 0x104–0x133: `sumA += byte` (16-bit wrap).
  - 0x40104–0x40133: `sumB += byte` (16-bit wrap).
  - Writes to any other address are ignored.
- **CAPTURE → DECODE** on the first cycle `dl_active`=0.
- **DECODE** lasts one cycle and registers the outputs:
  - mbc1: type 01–03. mbc2: 05–06. mmm01: 0B–0D. mbc3: 0F–13. mbc5: 19–1E. mbc6: 20. mbc7: 22. gb_camera: FC. tama: FD. huc3: FE. huc1: FF. Any other value leaves all selects at 0.
  - mbc30 = mbc3 & (romsz==7 | ramsz==5).
  - mbc1m = mbc1 & romsz==5 & sumB!=0 & sumA==sumB.
  - rom_mask = romsz≤8 ? (2<<romsz)-1 : 0x1FF.
  - ram_mask by ramsz: 0/1/2 → 0; 3 → 3; 4 → 15; 5 → 7; other → 0.
  - has_ram = ramsz!=0 | mbc2 | mbc7 | tama.
  - header_ok = (chk == hchk).
- **DECODE → DONE:** `hdr_valid`=1.
- **DONE** holds until `dl_active` rises again.
- **Reset:** on `reset`=1, state goes to IDLE and all outputs and capture registers go to 0. This applies at any point, including mid-download. A download interrupted by reset is not resumed; capture restarts only on a new 0→1 of `dl_active`.

## Timing
- All registers update on the `clk_sys` rising edge.
- Capture has no added latency; a byte counts on the cycle its `dl_wr` is sampled.
- Decoded outputs and `hdr_valid` are valid 2 cycles after `dl_active` is first sampled low.
- `dl_wr` in the cycle `dl_active` falls is ignored.
- `dl_active` high for a single cycle is still a full download. Every capture register is cleared, so an empty header decodes to type 0, no mapper, rom_mask 1, ram_mask 0, `has_ram` 0 (with CART_HDR_CHECKSUM_EN: chk=0, hchk=0, header_ok=1).
- A repeated write to the same address overwrites the stored byte. Checksum and sum accumulators add the repeated byte again.

## Configuration
- **`CART_HDR_CHECKSUM_EN` defined:** the `chk`/`hchk` logic is built and `header_ok` behaves as above.
- **Not defined:** that logic is omitted and `header_ok` equals `hdr_valid`.

## Test plan
- Header at 0x147/0x148/0x149 = 0x03/0x05/0x03, logo sums differ → mbc1=1, mbc1m=0, rom_mask=0x03F, ram_mask=3, has_ram=1, hdr_valid 2 cycles after `dl_active` falls.
- Same header with identical 48-byte logo also written at 0x40104 → mbc1m=1.
- Type 0x13, ramsz 0x05 → mbc3=1, mbc30=1, ram_mask=7. Type 0x06, ramsz 0 → mbc2=1, has_ram=1, ram_mask=0.
- Correct checksum byte at 0x14D, then the same with 0x14D+1 (checksum macro on) → header_ok 1, then 0. With the macro off, both cases give header_ok=1.
- Assert `reset` mid-CAPTURE after type 0x19 is written, then release with no new download → all outputs 0, hdr_valid stays 0.
- Second download of type 0xFF after a type 0x22 download → mbc7 drops to 0 when `dl_active` rises; huc1=1 two cycles after `dl_active` falls.
